// File: rtl/factorial_seq_ctrl.sv
// Sequenced n! engine: one OUT_W x IN_W multiply per cycle, result valid max(n,1) edges after accept; holds result while out_ready low.
// Build option FACT_OVF_SAT_EN: saturate out to all ones when the product chain overflows OUT_W bits.
module factorial_seq_ctrl #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf,
    output logic             busy
);
    localparam int PW = OUT_W + IN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [OUT_W-1:0]  acc;
    logic [IN_W-1:0]   cnt;
    logic              ovf_r;
    logic [PW-1:0]     prod;
    logic              more;
    logic [OUT_W-1:0]  result;

    assign prod = PW'(acc) * PW'(cnt);
    assign more = (cnt > IN_W'(1));

    // ovf_r is final at DONE entry: the last multiply happened on an earlier edge.
`ifdef FACT_OVF_SAT_EN
    assign result = ovf_r ? {OUT_W{1'b1}} : acc;
`else
    assign result = acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= OUT_W'(1);
            cnt   <= '0;
            ovf_r <= 1'b0;
            out   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= OUT_W'(1);
                        cnt   <= in;
                        ovf_r <= 1'b0;
                    end
                end
                CALC: begin
                    if (more) begin
                        acc   <= prod[OUT_W-1:0];
                        // Judge overflow on the full product so a wrapped acc cannot hide it.
                        ovf_r <= ovf_r | (|prod[PW-1:OUT_W]);
                        cnt   <= cnt - IN_W'(1);
                    end else begin
                        out <= result;
                        ovf <= ovf_r;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst)
                    next_state = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (!more)
                    next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Bench for factorial_seq_ctrl: directed literal cases plus random traffic against a countdown/factorial model.
module tb_factorial_seq_ctrl;
    localparam int IN_W  = 4;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_dat = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_dat;
    logic             ovf;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    factorial_seq_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in(in_dat),
        .out_valid(out_valid), .out_ready(out_ready), .out(out_dat),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint fact(input int n);
        longint f = 1;
        for (int k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    function automatic logic [OUT_W-1:0] exp_out(input int n);
        longint f = fact(n);
`ifdef FACT_OVF_SAT_EN
        if (f >= (64'd1 << OUT_W)) return {OUT_W{1'b1}};
`endif
        return f[OUT_W-1:0];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: one job in flight, done max(n,1) edges after accept.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    int               m_left = 0;
    logic [OUT_W-1:0] m_res = '0;
    logic             m_ovf = 1'b0;
    logic [OUT_W-1:0] m_last = '0;
    int               m_ops = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_last <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_left <= (in_dat > 1) ? int'(in_dat) : 1;
                m_res  <= exp_out(int'(in_dat));
                m_ovf  <= (fact(int'(in_dat)) >= (64'd1 << OUT_W));
            end
        end else if (!m_done) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_last <= m_res;
            end
        end else if (out_ready) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_ops <= m_ops + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, !m_busy);
            check("busy", busy, m_busy);
            check("out_valid", out_valid, m_done);
            check("out", out_dat, m_last);
            if (m_done) check("ovf", ovf, m_ovf);
        end
    end

    task automatic run_op(input int n, input longint lit_out, input bit lit_ovf,
                          input int lit_lat, input int hold, input bit noise);
        int edges = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_dat = IN_W'(n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && edges < 40) begin
            if (noise) begin in_valid = ~in_valid; in_dat = IN_W'(7); end
            @(posedge clk); #1;
            edges++;
        end
        check($sformatf("latency n=%0d", n), edges, lit_lat);
        check($sformatf("lit out n=%0d", n), out_dat, lit_out);
        check($sformatf("lit ovf n=%0d", n), ovf, lit_ovf);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin in_valid = ~in_valid; in_dat = IN_W'(7); end
            @(posedge clk); #1;
            check("held out_valid", out_valid, 1);
            check("held out", out_dat, lit_out);
        end
        if (noise) begin in_valid = 1'b1; in_dat = IN_W'(7); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("idle after handshake", in_ready, 1);
    endtask

    initial begin
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset ovf", ovf, 0);
        check("reset out", out_dat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check("in_ready after release", in_ready, 1);

        run_op(0, 1, 0, 1, 0, 0);
        run_op(1, 1, 0, 1, 0, 0);
        run_op(5, 120, 0, 5, 0, 0);
        run_op(8, 40320, 0, 8, 0, 0);
`ifdef FACT_OVF_SAT_EN
        run_op(9, 16'hFFFF, 1, 9, 0, 0);
`else
        run_op(9, 16'h8980, 1, 9, 0, 0);
`endif
        run_op(3, 6, 0, 3, 0, 0);
        run_op(4, 24, 0, 4, 10, 1);
        run_op(7, 5040, 0, 7, 0, 0);

        // Reset in the third CALC cycle of n = 7.
        @(posedge clk); #1;
        in_valid = 1'b1; in_dat = IN_W'(7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset busy", busy, 0);
        check("mid reset ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check("in_ready after mid reset", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("no pulse after reset", out_valid, 0);
        end
        run_op(2, 2, 0, 2, 0, 0);

        // Random traffic, occasional reset, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_dat    = IN_W'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (m_ops < 50) begin
            n_bad++;
            $display("FAIL random progress: completed %0d, expected at least 50", m_ops);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/factorial_seq_ctrl.md
Name: factorial_seq_ctrl

Overview:
Sequenced factorial engine. It replaces the combinational loop evaluation with an FSM that reuses one OUT_W x IN_W multiplier, doing one multiply per cycle. It accepts an operand over a valid/ready handshake, iterates acc = acc*cnt down to cnt = 1, and returns the result over a second valid/ready handshake. It sits between a requesting master and downstream logic that consumes n!.

Parameters:
IN_W, 4, operand width; n ranges 0..2^IN_W-1
OUT_W, 16, result width; default holds up to 8! = 40320

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand valid
in_ready  output  1  engine can accept operand
in  input  IN_W  operand n
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  OUT_W  n! (low OUT_W bits, or saturated, see Optional Feature)
ovf  output  1  result exceeded OUT_W bits; valid while out_valid
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state = IDLE, acc = 1, cnt = 0, out = 0, ovf = 0, out_valid = 0, busy = 0; in_ready = 1 once rst deasserts.
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: acc <= 1, cnt <= in, ovf_r <= 0, go to CALC.
  - in is sampled only on the handshake edge.
- CALC:
  - in_ready = 0; busy = 1.
  - If cnt > 1: prod = acc * cnt, computed at OUT_W+IN_W bits. acc <= prod[OUT_W-1:0]. ovf_r <= ovf_r | (prod[OUT_W+IN_W-1:OUT_W] != 0). cnt <= cnt - 1.
  - If cnt <= 1: go to DONE. out <= acc (saturated if the feature is enabled), ovf <= ovf_r.
- DONE:
  - out_valid = 1; out and ovf are stable.
  - On out_ready: go to IDLE, out_valid <= 0.
  - Hold indefinitely while out_ready = 0 (backpressure).
- Latency:
  - out_valid rises exactly max(n,1) clock edges after the accepting edge.
  - n = 0 and n = 1 give 1 edge and out = 1.
  - n = 5 gives 5 edges (4 multiplies plus the exit cycle).
- Throughput:
  - At most one operation in flight.
  - in_ready is low from the accept edge until the cycle after the out handshake.
  - No operand is accepted in the same cycle as the out handshake; back-to-back gap is 1 cycle in IDLE.
- ovf:
  - Sticky within an operation; cleared on the next accept.
  - Evaluated on the full-width product every multiply, so wrapped intermediate values never mask an overflow.
- in_valid while busy is ignored; no operand is captured or queued.
- out_ready outside DONE has no effect.
- Reset mid-operation: asynchronous return to IDLE with reset values. The partial result is discarded; no out_valid pulse.
- out holds its last value in IDLE and CALC; it is only meaningful while out_valid = 1.

Optional Feature:
- Macro: FACT_OVF_SAT_EN.
- Defined: when ovf_r is set at DONE entry, out <= all ones ({OUT_W{1'b1}}); ovf still reported.
- Undefined: out <= truncated low OUT_W bits of the true product chain (acc); ovf still reported.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset check: assert rst asynchronously mid-clock -> out_valid = 0, busy = 0, ovf = 0 immediately; in_ready = 1 after release.
- n = 0, then n = 1 -> out = 1, ovf = 0; out_valid 1 edge after accept.
- n = 5 -> out = 120 after exactly 5 edges. n = 8 -> out = 40320 (0x9D80), ovf = 0, after 8 edges.
- n = 9:
  - Without FACT_OVF_SAT_EN: out = 362880 mod 65536 = 0x8980, ovf = 1.
  - With FACT_OVF_SAT_EN: out = 0xFFFF, ovf = 1.
  - Then n = 3 -> out = 6, ovf = 0 (sticky cleared).
- Backpressure: n = 4 with out_ready = 0 for 10 cycles -> out = 24 held stable, out_valid held. in_valid pulses with n = 7 during CALC/DONE are ignored. out_ready = 1 -> IDLE, next accept gives out = 5040.
- Reset during CALC of n = 7 (3rd cycle) -> no out_valid. Next n = 2 -> out = 2 after 2 edges.
